// File: rtl/receive_eng_if.sv
// Host-side bundle for the serial receive engine: the serial line, the frame
// configuration, the read strobe and the received byte with its status flags.
interface receive_eng_if;
    logic       rx;
    logic [3:0] baud;
    logic       eight;
    logic       parity_en;
    logic       odd_n_even;
    logic       read;
    logic [7:0] rx_data;
    logic       rxrdy;
    logic       perr;
    logic       ferr;
    logic       ovf;

    modport master (
        output rx, baud, eight, parity_en, odd_n_even, read,
        input  rx_data, rxrdy, perr, ferr, ovf
    );

    modport slave (
        input  rx, baud, eight, parity_en, odd_n_even, read,
        output rx_data, rxrdy, perr, ferr, ovf
    );
endinterface

// File: rtl/receive_eng.sv
// Asynchronous serial receiver: start-bit qualification at half a bit time,
// mid-bit sampling of 7/8 data bits, optional parity and one stop bit, with a
// single-entry result register carrying parity/framing/overrun status.
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronized line
// START | timing half a bit to confirm the start bit is still low
// DATA  | sampling data, parity and stop bits once per bit time
// DONE  | single cycle that publishes the frame to the host registers
module receive_eng (
    input  logic         CLK,
    input  logic         RESET,
    receive_eng_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;

    state_t      state, state_nxt;
    logic        rx_meta, rx_sync, rx_prev;
    logic [18:0] cnt;
    logic [3:0]  bit_cnt;
    logic [9:0]  shreg;
    logic [3:0]  baud_l;
    logic        eight_l, par_l, odd_l;
    logic [18:0] bt_start, bt_frame;
    logic [3:0]  frame_len;
    logic        half_hit, bit_hit, last_bit;
    logic        confirm, sample;
    logic [9:0]  aligned;
    logic [7:0]  data_byte;
    logic        par_bit, stop_bit, perr_calc;
    logic [7:0]  rx_data_r;
    logic        rxrdy_r, perr_r, ferr_r, ovf_r;

    function automatic logic [18:0] bit_time(input logic [3:0] b);
        case (b)
            4'd1:    bit_time = 19'd83333;
            4'd2:    bit_time = 19'd41667;
            4'd3:    bit_time = 19'd20833;
            4'd4:    bit_time = 19'd10417;
            4'd5:    bit_time = 19'd5208;
            4'd6:    bit_time = 19'd2604;
            4'd7:    bit_time = 19'd1736;
            4'd8:    bit_time = 19'd868;
            4'd9:    bit_time = 19'd434;
            4'd10:   bit_time = 19'd217;
            4'd11:   bit_time = 19'd109;
            default: bit_time = 19'd333333;
        endcase
    endfunction

    // The start half-bit uses the live rate; the frame uses the rate latched at confirmation.
    assign bt_start  = bit_time(bus.baud);
    assign bt_frame  = bit_time(baud_l);
    assign half_hit  = (cnt == (bt_start >> 1));
    assign bit_hit   = (cnt == bt_frame);
    assign frame_len = (eight_l ? 4'd8 : 4'd7) + {3'b000, par_l} + 4'd1;
    assign last_bit  = (bit_cnt == (frame_len - 4'd1));

    // Bits enter at the top of the shift register, so the first data bit sits
    // at position 10-frame_len once the stop bit has been shifted in.
    assign aligned   = shreg >> (4'd10 - frame_len);
    assign data_byte = eight_l ? aligned[7:0] : {1'b0, aligned[6:0]};
    assign par_bit   = eight_l ? aligned[8] : aligned[7];
    assign stop_bit  = aligned[frame_len - 4'd1];
    assign perr_calc = par_l & ((^data_byte ^ par_bit) != odd_l);

    // Two-flop synchronizer plus one history flop for edge detection; idles high.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and the confirm/sample strobes for the datapath.
    always_comb begin
        state_nxt = state;
        confirm   = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_prev && !rx_sync) state_nxt = START;
            end
            START: begin
                if (half_hit) begin
                    if (!rx_sync) begin
                        confirm   = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_hit) begin
                    sample = 1'b1;
                    if (last_bit) state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit-time counter restarts on every state change and after every sample.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if ((state_nxt != state) || sample) begin
            cnt <= '0;
        end else if ((state == START) || (state == DATA)) begin
            cnt <= cnt + 19'd1;
        end else begin
            cnt <= '0;
        end
    end

    // Per-frame capture: configuration snapshot at confirmation, then shifted bits.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bit_cnt <= '0;
            shreg   <= '0;
            baud_l  <= '0;
            eight_l <= 1'b0;
            par_l   <= 1'b0;
            odd_l   <= 1'b0;
        end else if (confirm) begin
            bit_cnt <= '0;
            shreg   <= '0;
            baud_l  <= bus.baud;
            eight_l <= bus.eight;
            par_l   <= bus.parity_en;
            odd_l   <= bus.odd_n_even;
        end else if (sample) begin
            bit_cnt <= bit_cnt + 4'd1;
            shreg   <= {rx_sync, shreg[9:1]};
        end
    end

    // Host result register: a completed frame always wins over a coincident read.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_data_r <= 8'h00;
            rxrdy_r   <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else if (state == DONE) begin
            rx_data_r <= data_byte;
            rxrdy_r   <= 1'b1;
            perr_r    <= perr_calc;
            ferr_r    <= ~stop_bit;
            ovf_r     <= rxrdy_r & ~bus.read;
        end else if (bus.read && rxrdy_r) begin
            rxrdy_r   <= 1'b0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end
    end

    assign bus.rx_data = rx_data_r;
    assign bus.rxrdy   = rxrdy_r;
    assign bus.perr    = perr_r;
    assign bus.ferr    = ferr_r;
    assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_receive_eng.sv
// Bench for receive_eng: directed and randomized frames at BAUD=11 checked
// against a frame-level model of the host-visible result register.
module tb_receive_eng;

    logic CLK = 1'b0;
    logic RESET;

    receive_eng_if bus();

    receive_eng dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    localparam int BIT_CYC = 109;

    int total  = 0;
    int passed = 0;

    logic [7:0] m_data;
    logic       m_rxrdy, m_perr, m_ferr, m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rx_data"}, 32'(bus.rx_data), 32'(m_data));
        check({tag, ".rxrdy"},   32'(bus.rxrdy),   32'(m_rxrdy));
        check({tag, ".perr"},    32'(bus.perr),    32'(m_perr));
        check({tag, ".ferr"},    32'(bus.ferr),    32'(m_ferr));
        check({tag, ".ovf"},     32'(bus.ovf),     32'(m_ovf));
    endtask

    task automatic model_reset();
        m_data  = 8'h00;
        m_rxrdy = 1'b0;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Frame-level reference: what the host must see once a frame has completed.
    task automatic model_frame(input logic [7:0] d, input logic eight, input logic pen,
                               input logic odd, input logic pbit, input logic stop,
                               input logic rd_in_done);
        logic [7:0] dd;
        int ones;
        dd   = eight ? d : (d & 8'h7F);
        ones = $countones(dd) + int'(pbit);
        m_ovf   = m_rxrdy && !rd_in_done;
        m_data  = dd;
        m_rxrdy = 1'b1;
        m_perr  = pen && ((ones % 2) != int'(odd));
        m_ferr  = !stop;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic eight, input logic pen,
                              input logic pbit, input logic stop);
        int nd;
        nd = eight ? 8 : 7;
        bus.rx = 1'b0;
        idle(BIT_CYC);
        for (int i = 0; i < nd; i++) begin
            bus.rx = d[i];
            idle(BIT_CYC);
        end
        if (pen) begin
            bus.rx = pbit;
            idle(BIT_CYC);
        end
        bus.rx = stop;
        idle(BIT_CYC);
        bus.rx = 1'b1;
        idle(20);
    endtask

    task automatic do_read();
        bus.read = 1'b1;
        @(negedge CLK);
        bus.read = 1'b0;
        if (m_rxrdy) begin
            m_rxrdy = 1'b0;
            m_perr  = 1'b0;
            m_ferr  = 1'b0;
            m_ovf   = 1'b0;
        end
        idle(2);
    endtask

    // Full frame using the current config inputs, optionally with READ pulsed in
    // the single cycle where the stop-bit result is published: 2 sync cycles and
    // the edge cycle, BT/2+1 to confirm, then BT+1 per sample.
    task automatic frame(input logic [7:0] d, input logic pbit, input logic stop,
                         input logic rd_in_done);
        int n;
        logic eight, pen, odd;
        eight = bus.eight;
        pen   = bus.parity_en;
        odd   = bus.odd_n_even;
        n = (eight ? 8 : 7) + int'(pen) + 1;
        if (rd_in_done) begin
            fork
                send_frame(d, eight, pen, pbit, stop);
                begin
                    idle(168 + (BIT_CYC + 1) * (n - 1));
                    bus.read = 1'b1;
                    @(negedge CLK);
                    bus.read = 1'b0;
                end
            join
        end else begin
            send_frame(d, eight, pen, pbit, stop);
        end
        model_frame(d, eight, pen, odd, pbit, stop, rd_in_done);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rp, rs, rr;

        RESET          = 1'b1;
        bus.rx         = 1'b1;
        bus.read       = 1'b0;
        bus.baud       = 4'd11;
        bus.eight      = 1'b1;
        bus.parity_en  = 1'b0;
        bus.odd_n_even = 1'b0;
        model_reset();
        idle(5);
        check_all("reset");
        RESET = 1'b0;
        idle(10);

        // 8N1 0x55, then read clears ready
        frame(8'h55, 1'b0, 1'b1, 1'b0);
        check_all("8n1_55");
        do_read();
        check_all("8n1_55_read");
        do_read();
        check_all("read_when_empty");

        // 8 bits even parity, 0xA7 with each parity value
        bus.parity_en  = 1'b1;
        bus.odd_n_even = 1'b0;
        frame(8'hA7, 1'b1, 1'b1, 1'b0);
        check_all("8e_a7_p1");
        do_read();
        frame(8'hA7, 1'b0, 1'b1, 1'b0);
        check_all("8e_a7_p0");
        do_read();

        // 7 bits odd parity, 0x41, good stop then bad stop
        bus.eight      = 1'b0;
        bus.odd_n_even = 1'b1;
        frame(8'h41, 1'b1, 1'b1, 1'b0);
        check_all("7o_41");
        do_read();
        frame(8'h41, 1'b1, 1'b0, 1'b0);
        check_all("7o_41_ferr");
        do_read();

        // Short low glitch must not start a frame
        bus.eight     = 1'b1;
        bus.parity_en = 1'b0;
        bus.rx = 1'b0;
        idle(20);
        bus.rx = 1'b1;
        idle(100);
        check_all("glitch");
        frame(8'h3C, 1'b0, 1'b1, 1'b0);
        check_all("after_glitch_3c");
        do_read();

        // Overrun, then the same pair with READ landing in the publishing cycle
        frame(8'h11, 1'b0, 1'b1, 1'b0);
        frame(8'h22, 1'b0, 1'b1, 1'b0);
        check_all("ovf_set");
        do_read();
        frame(8'h11, 1'b0, 1'b1, 1'b0);
        frame(8'h22, 1'b0, 1'b1, 1'b1);
        check_all("read_in_done");
        do_read();

        // Config inputs wiggled mid-frame must not affect the frame in flight
        fork
            frame(8'h9A, 1'b0, 1'b1, 1'b0);
            begin
                idle(300);
                bus.eight      = 1'b0;
                bus.parity_en  = 1'b1;
                bus.odd_n_even = 1'b1;
                bus.baud       = 4'd0;
                idle(300);
                bus.eight      = 1'b1;
                bus.parity_en  = 1'b0;
                bus.odd_n_even = 1'b1;
                bus.baud       = 4'd11;
            end
        join
        check_all("cfg_midframe");

        // Reset in the middle of a 0xFF frame while a byte is still pending
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
            begin
                idle(400);
                RESET = 1'b1;
                #1;
                model_reset();
                check_all("async_reset");
                @(negedge CLK);
                RESET = 1'b0;
            end
        join
        check_all("after_reset");
        frame(8'h81, 1'b0, 1'b1, 1'b0);
        check_all("post_reset_81");
        do_read();

        // Randomized frames against the model
        for (int k = 0; k < 8; k++) begin
            bus.eight      = 1'($urandom_range(0, 1));
            bus.parity_en  = 1'($urandom_range(0, 1));
            bus.odd_n_even = 1'($urandom_range(0, 1));
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) do_read();
            frame(rd, rp, rs, rr);
            check_all($sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
